// File: rtl/fibo_blink_pkg.sv
// Shared widths, reset values and helpers for the Fibonacci blinker.
package fibo_blink_pkg;

  localparam int unsigned FIB_W        = 8;
  localparam int unsigned IDX_W        = 6;
  localparam int unsigned SPEED_STRIDE = 3;
  localparam int unsigned SPEED_W      = 3;
  localparam int unsigned PRESCALE_W   = 22;
  localparam int unsigned PIN_W        = 8;

  localparam int unsigned RUN_BIT   = 0;
  localparam int unsigned STEP_BIT  = 1;
  localparam int unsigned SPEED_LSB = 2;

  localparam logic [FIB_W-1:0] A_RST     = 8'd0;
  localparam logic [FIB_W-1:0] B_RST     = 8'd1;
  localparam logic [FIB_W-1:0] LAST_TERM = 8'd233;
  localparam logic [IDX_W-1:0] IDX_RST   = '0;

  // Layout of uio_out: {index, wrap, led}
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             led;
  } status_t;

  // Prescaler terminal count for a speed select: 2^(3*s) - 1
  function automatic logic [PRESCALE_W-1:0] speed_th(input logic [SPEED_W-1:0] s);
    logic [PRESCALE_W:0] one_hot;
    one_hot = (PRESCALE_W+1)'(1) << (SPEED_STRIDE * 32'(s));
    return PRESCALE_W'(one_hot - (PRESCALE_W+1)'(1));
  endfunction

endpackage

// File: rtl/fibo_blink_if.sv
// Tiny Tapeout style pin bundle between the harness and the Fibonacci core.
interface fibo_blink_if;
  import fibo_blink_pkg::*;

  logic             ena;
  logic [PIN_W-1:0] ui_in;
  logic [PIN_W-1:0] uio_in;
  logic [PIN_W-1:0] uo_out;
  logic [PIN_W-1:0] uio_out;
  logic [PIN_W-1:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/fibo_step_sync.sv
// Two-flop synchronizer for the step button plus a rising-edge detector.
module fibo_step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic pulse
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else if (en) begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/tt_um_fibo_blink.sv
// Tiny Tapeout flat-pin wrapper around fibo_blink.
module tt_um_fibo_blink (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  fibo_blink_if u_if ();

  assign u_if.ena    = ena;
  assign u_if.ui_in  = ui_in;
  assign u_if.uio_in = uio_in;
  assign uo_out      = u_if.uo_out;
  assign uio_out     = u_if.uio_out;
  assign uio_oe      = u_if.uio_oe;

  fibo_blink u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

endmodule

// File: rtl/fibo_blink.sv
// Fibonacci term generator: free-run, prescaled or single-step advance.
module fibo_blink
  import fibo_blink_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fibo_blink_if.slave  bus
);

  logic                  run;
  logic [SPEED_W-1:0]    speed;
  logic                  step_pulse;
  logic                  tick;
  logic                  advance;
  logic [PRESCALE_W-1:0] th;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [FIB_W-1:0]      a_q, a_d;
  logic [FIB_W-1:0]      b_q, b_d;
  status_t               st_q, st_d;
  logic                  unused_ok;

  assign run   = bus.ui_in[RUN_BIT];
  assign speed = bus.ui_in[SPEED_LSB +: SPEED_W];

  fibo_step_sync u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.ena),
    .din   (bus.ui_in[STEP_BIT]),
    .pulse (step_pulse)
  );

  // Tick source and single-advance arbitration
  always_comb begin
    th      = speed_th(speed);
    tick    = run & (presc_q >= th);
    advance = tick | (~run & step_pulse);
    presc_d = '0;
    if (run && !tick) presc_d = presc_q + PRESCALE_W'(1);
  end

  // Wrap keys on the displayed term so 233 is shown before restarting at 0
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    st_d     = st_q;
    st_d.wrap = 1'b0;
    if (advance) begin
      st_d.led = ~st_q.led;
      if (a_q == LAST_TERM) begin
        a_d       = A_RST;
        b_d       = B_RST;
        st_d.idx  = IDX_RST;
        st_d.wrap = 1'b1;
      end else begin
        a_d      = b_q;
        b_d      = a_q + b_q;
        st_d.idx = st_q.idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      a_q     <= A_RST;
      b_q     <= B_RST;
      st_q    <= '0;
    end else if (bus.ena) begin
      presc_q <= presc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      st_q    <= st_d;
    end
  end

  assign bus.uo_out  = a_q;
  assign bus.uio_out = st_q;
  assign bus.uio_oe  = 8'hFF;

  assign unused_ok = &{1'b0, bus.uio_in, bus.ui_in[PIN_W-1:SPEED_LSB+SPEED_W]};

endmodule

// File: tb/tb_fibo_blink.sv
// Scoreboard bench for fibo_blink: expected pins are queued per clock and checked after the edge.
module tb_fibo_blink;
  import fibo_blink_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  fibo_blink_if bus ();

  fibo_blink u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_idx;
  bit   m_led;
  bit   m_wrap;
  logic [7:0] fib_tab [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                               8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  task automatic model_reset();
    m_idx  = 0;
    m_led  = 1'b0;
    m_wrap = 1'b0;
    sb.delete();
  endtask

  // One clock: predict the post-edge pins, queue them, land 1 time unit after the edge
  task automatic clk_model(input bit adv, input bit frz);
    exp_t e;
    @(posedge clk);
    if (!frz) begin
      if (adv) begin
        m_wrap = (m_idx == 13);
        m_idx  = m_wrap ? 0 : m_idx + 1;
        m_led  = ~m_led;
      end else begin
        m_wrap = 1'b0;
      end
    end
    e.uo  = fib_tab[m_idx];
    e.uio = {6'(m_idx), m_wrap, m_led};
    sb.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t e;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    rst_n      = 1'b0;
    model_reset();
    #3;
    n_cmp++;
    if (bus.uo_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_uo got %02h want 00", bus.uo_out);
    end
    n_cmp++;
    if (bus.uio_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_uio got %02h want 00", bus.uio_out);
    end
    n_cmp++;
    if (bus.uio_oe !== 8'hFF) begin
      n_bad++;
      $display("FAIL reset_oe got %02h want FF", bus.uio_oe);
    end
    #9;
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      clk_model(1'b0, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
        n_bad++;
        $display("FAIL idle_hold[%0d] uo/uio got %02h/%02h want %02h/%02h",
                 c, bus.uo_out, bus.uio_out, e.uo, e.uio);
      end
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    bus.ui_in = 8'b000_000_01;
    n_cmp++;
    if (bus.uo_out !== 8'd0) begin
      n_bad++;
      $display("FAIL free_run_start got %02h want 00", bus.uo_out);
    end
    for (int c = 0; c < 16; c++) begin
      clk_model(1'b1, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
        n_bad++;
        $display("FAIL free_run[%0d] uo/uio got %02h/%02h want %02h/%02h",
                 c, bus.uo_out, bus.uio_out, e.uo, e.uio);
      end
    end
  endtask

  task automatic test_prescale();
    exp_t e;
    bus.ui_in = 8'b000_001_01;
    for (int c = 0; c < 27; c++) begin
      clk_model((c % 8) == 7, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
        n_bad++;
        $display("FAIL prescale[%0d] uo/uio got %02h/%02h want %02h/%02h",
                 c, bus.uo_out, bus.uio_out, e.uo, e.uio);
      end
    end
    bus.ui_in = 8'b000_000_01;
    clk_model(1'b1, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
      n_bad++;
      $display("FAIL speed_switch uo/uio got %02h/%02h want %02h/%02h",
               bus.uo_out, bus.uio_out, e.uo, e.uio);
    end
    bus.ui_in = 8'h00;
    clk_model(1'b0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
      n_bad++;
      $display("FAIL run_stop uo/uio got %02h/%02h want %02h/%02h",
               bus.uo_out, bus.uio_out, e.uo, e.uio);
    end
  endtask

  task automatic test_step();
    exp_t e;
    bus.ui_in = 8'h00;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      bus.ui_in = 8'b000_000_10;
      for (int c = 0; c < 20; c++) begin
        clk_model(c == 2, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
          n_bad++;
          $display("FAIL step_hold[%0d.%0d] uo/uio got %02h/%02h want %02h/%02h",
                   p, c, bus.uo_out, bus.uio_out, e.uo, e.uio);
        end
      end
      bus.ui_in = 8'h00;
      for (int c = 0; c < 4; c++) begin
        clk_model(1'b0, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
          n_bad++;
          $display("FAIL step_release[%0d.%0d] uo/uio got %02h/%02h want %02h/%02h",
                   p, c, bus.uo_out, bus.uio_out, e.uo, e.uio);
        end
      end
    end
    n_cmp++;
    if (bus.uo_out !== 8'd5 || bus.uio_out[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL step_final uo/led got %02h/%0b want 05/1", bus.uo_out, bus.uio_out[0]);
    end
  endtask

  task automatic test_ena();
    exp_t e;
    bus.ui_in = 8'b000_000_01;
    for (int c = 0; c < 18; c++) begin
      bus.ena = !(c >= 4 && c < 14);
      clk_model(1'b1, !bus.ena);
      e = sb.pop_front();
      n_cmp++;
      if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
        n_bad++;
        $display("FAIL ena_gate[%0d] uo/uio got %02h/%02h want %02h/%02h",
                 c, bus.uo_out, bus.uio_out, e.uo, e.uio);
      end
    end
    bus.ena = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.ui_in = 8'h00;
    do_reset();
    bus.ui_in = 8'b000_000_01;
    for (int c = 0; c < 11; c++) clk_model(1'b1, 1'b0);
    sb.delete();
    n_cmp++;
    if (bus.uo_out !== 8'd89) begin
      n_bad++;
      $display("FAIL pre_reset got %02h want 59", bus.uo_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.uo_out !== 8'd0 || bus.uio_out[7:2] !== 6'd0) begin
      n_bad++;
      $display("FAIL async_reset uo/idx got %02h/%0d want 00/0", bus.uo_out, bus.uio_out[7:2]);
    end
    #12;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_free_run();
    test_prescale();
    test_step();
    test_ena();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
